// File: rtl/e_mdu_ctrl_if.sv
// Handshake bundle between the E-stage pipeline and the MDU scheduler.
// The pipeline side is the master; the scheduler (e_mdu_ctrl) is the slave.
interface e_mdu_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req;
    logic [3:0]       e_mduOp;
    logic             e_start;
    logic             d_mdu_use;
    logic             mdu_start;
    logic             busy;
    logic             done;
    logic             stall_d;
    logic [CNT_W-1:0] mult_cnt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    modport master (
        output req, e_mduOp, e_start, d_mdu_use,
        input  mdu_start, busy, done, stall_d, mult_cnt, div_cnt, stall_cnt, err
    );

    modport slave (
        input  req, e_mduOp, e_start, d_mdu_use,
        output mdu_start, busy, done, stall_d, mult_cnt, div_cnt, stall_cnt, err
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide scheduler: issues MDU ops, mirrors MDU latency,
// stalls D-stage HI/LO users, and keeps saturating perf counters plus a sticky error.
module e_mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    e_mdu_ctrl_if.slave    mdu
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] mult_cnt_q, div_cnt_q, stall_cnt_q;
    logic             err_q;

    logic op_valid_s;
    logic op_mult_s;
    logic op_mt_s;
    logic issue_s;
    logic stall_s;
    logic err_set_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign op_valid_s = (mdu.e_mduOp >= 4'd1) && (mdu.e_mduOp <= 4'd4);
    assign op_mult_s  = (mdu.e_mduOp == 4'd1) || (mdu.e_mduOp == 4'd2);
    assign op_mt_s    = (mdu.e_mduOp == 4'd5) || (mdu.e_mduOp == 4'd6);
    assign issue_s    = (state_q == IDLE) && mdu.e_start && !mdu.req && op_valid_s;
    assign stall_s    = mdu.d_mdu_use && (busy_q || issue_s);
    // Illegal ops are ignored by the FSM; they only raise the sticky flag.
    assign err_set_s  = (busy_q && (mdu.e_start || op_mt_s)) || (mdu.e_start && !op_valid_s);

    // Next-state, latency countdown and registered busy/done outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    if (op_mult_s) begin
                        state_d = MBUSY;
                        cnt_d   = LAT_W'(MULT_LAT);
                    end else begin
                        state_d = DBUSY;
                        cnt_d   = LAT_W'(DIV_LAT);
                    end
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            MBUSY, DBUSY: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - LAT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Saturating performance counters and sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult_cnt_q  <= '0;
            div_cnt_q   <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mult_cnt_q  <= sat_inc(mult_cnt_q, issue_s && op_mult_s);
            div_cnt_q   <= sat_inc(div_cnt_q, issue_s && !op_mult_s);
            stall_cnt_q <= sat_inc(stall_cnt_q, stall_s);
            err_q       <= err_q || err_set_s;
        end
    end

    assign mdu.mdu_start = issue_s;
    assign mdu.stall_d   = stall_s;
    assign mdu.busy      = busy_q;
    assign mdu.done      = done_q;
    assign mdu.mult_cnt  = mult_cnt_q;
    assign mdu.div_cnt   = div_cnt_q;
    assign mdu.stall_cnt = stall_cnt_q;
    assign mdu.err       = err_q;
endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Scheduler and hazard controller for the E-stage multiply/divide unit (MDU).
- Decides when an E-stage mult/div may issue to the MDU and tracks the MDU latency with its own countdown.
- Generates the D-stage stall for any instruction that touches HI/LO while an operation is in flight.
- Provides saturating performance counters and a sticky protocol-error flag.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu; must match the MDU.
- DIV_LAT, 10, busy cycles for div/divu; must match the MDU.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  exception/interrupt request; suppresses issue this cycle.
- e_mduOp  input  4  E-stage MDU op. Encoding: 0 nope, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.
- e_start  input  1  E-stage instruction is mult/multu/div/divu.
- d_mdu_use  input  1  D-stage instruction reads or writes HI/LO (ops 1-8).
- mdu_start  output  1  start strobe forwarded to the MDU; combinational.
- busy  output  1  mirror of MDU busy; registered.
- done  output  1  one-cycle pulse when HI/LO become valid; registered.
- stall_d  output  1  stall D stage; combinational.
- mult_cnt  output  CNT_W  issued mult/multu count.
- div_cnt  output  CNT_W  issued div/divu count.
- stall_cnt  output  CNT_W  cycles with stall_d high.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset: state IDLE; cnt=0; busy=0; done=0; err=0; all counters 0. A reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, MBUSY, DBUSY.
- Issue condition: issue = (state==IDLE) && e_start && !req && e_mduOp in {1..4}.
- mdu_start = issue, combinational.
- IDLE -> MBUSY on issue with op 1 or 2; cnt loads MULT_LAT.
- IDLE -> DBUSY on issue with op 3 or 4; cnt loads DIV_LAT.
- In MBUSY/DBUSY, cnt decrements each cycle. busy=1 for exactly LAT cycles, starting the cycle after issue.
- When cnt==1: next edge returns to IDLE, busy=0, done=1 for one cycle. HI/LO are valid in the done cycle.
- Issue in the done cycle is legal (state is already IDLE). Back-to-back ops are therefore separated by exactly LAT cycles of busy.
- req=1 with e_start=1 in IDLE: no issue, state stays IDLE, mdu_start=0, no counter increment.
- req during MBUSY/DBUSY: no effect; the committed operation completes normally.
- stall_d = d_mdu_use && (busy || issue). Op 0 never stalls. A D-stage mfhi/mflo behind an issuing mult therefore stalls from the issue cycle.
- stall_cnt increments every cycle stall_d=1, including cycles where req=1.
- mult_cnt / div_cnt increment on each issue of their class.
- All counters saturate at 2^CNT_W-1 and never wrap.
- err sets (sticky until reset) when, while busy=1, either e_start=1 or e_mduOp is in {5,6}. The offending op is ignored: no restart, cnt unchanged.
- e_start=1 with e_mduOp outside {1..4}: no issue, err is set.

Test Plan:
- Single mult: e_mduOp=1, e_start=1 at cycle 0 -> mdu_start=1 at cycle 0; busy=1 cycles 1-5; done=1 at cycle 6; mult_cnt=1.
- Divu with D-stage mflo behind it: op 4 issued at cycle 0, d_mdu_use=1 held -> stall_d=1 cycles 0-10; stall_d=0 at cycle 11 (done); stall_cnt=11; div_cnt=1.
- Issue blocked by req: e_start=1, op 3, req=1 for one cycle -> mdu_start=0, busy stays 0, div_cnt=0. Same op with req=0 next cycle -> issues normally.
- Back-to-back: mult issued at cycle 0, div issued in the done cycle 6 -> busy=1 cycles 1-5 and 7-16; done at cycles 6 and 17.
- Protocol error: e_start=1 with op 1 during DBUSY -> err=1 sticky, cnt unchanged, done arrives on the original schedule. Reset at cycle 3 of a div -> busy=0, done never pulses, err=0.
- Saturation: force 2^16+5 mult issues -> mult_cnt holds 0xFFFF.
